apb_acc_sequencer: RTL and testbench
====================================

// Module: apb_acc_sequencer
// PURPOSE
//  APB master-side controller that runs accumulator commands against the APB accumulator slave.
//  Slave register map: addend @BASE+0x0, control @BASE+0x4 (1=add, 2=clear), result @BASE+0x8 (RO).
//  Accepts one command at a time (ADD/CLEAR/READ) on a valid/ready port and sequences the APB transfers.
//  Returns the read-back result on a response valid/ready port.
// PARAMETERS
//  ADDR_W     32         APB address width
//  DATA_W     32         APB data / operand / result width
//  BASE_ADDR  'h0        slave base address; offsets 0x0/0x4/0x8 are added modulo 2^ADDR_W
//  SETTLE_CYC 2          idle cycles between the control write and the result read (0..15)
//  TIMEOUT    16         max ACCESS cycles waiting for PREADY (only with ACC_SEQ_TIMEOUT_EN)
// PORTS
//  PCLK       in   1       clock; all logic on rising edge
//  PRESETn    in   1       asynchronous active-low reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
//  cmd_op     in   2       0=ADD, 1=CLEAR, 2=READ, 3=reserved
//  cmd_data   in   DATA_W  addend for ADD; ignored otherwise
//  rsp_valid  out  1       response available
//  rsp_ready  in   1       response consumed when rsp_valid & rsp_ready
//  rsp_data   out  DATA_W  result register value (0 on error)
//  rsp_err    out  1       PSLVERR, timeout or reserved op
//  PADDR      out  ADDR_W  APB address
//  PSEL       out  1       APB select
//  PENABLE    out  1       APB enable
//  PWRITE     out  1       APB direction (1 = write)
//  PWDATA     out  DATA_W  APB write data
//  PRDATA     in   DATA_W  APB read data
//  PREADY     in   1       APB ready
//  PSLVERR    in   1       APB slave error
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = IDLE, captured command discarded.
//    Reset asserted mid-transfer drops PSEL/PENABLE immediately; no response is issued.
//  - cmd_ready = 1 only in IDLE with rsp_valid = 0. The command is captured at acceptance.
//  - Transfer lists:
//    - ADD:   W(BASE+0, cmd_data), W(BASE+4, 1), SETTLE, R(BASE+8)
//    - CLEAR: W(BASE+4, 2), SETTLE, R(BASE+8)
//    - READ:  R(BASE+8)
//    - op 3:  no APB activity; rsp_valid the cycle after acceptance with err = 1, data = 0.
//  - FSM states: IDLE -> SETUP -> ACCESS -> (next SETUP | SETTLE | RESP); SETTLE -> SETUP; RESP -> IDLE.
//  - SETUP: one cycle, PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA valid and held stable through ACCESS.
//  - ACCESS: PSEL=1, PENABLE=1, repeated until PREADY=1.
//    The transfer completes on the edge where PREADY=1; PRDATA is sampled then on reads.
//  - Back-to-back transfers: the next SETUP follows immediately. PSEL drops to 0 in SETTLE/RESP/IDLE.
//  - SETTLE: exactly SETTLE_CYC cycles with PSEL=0; if SETTLE_CYC = 0 the state is skipped.
//  - PSLVERR=1 on a completing ACCESS aborts the remaining list -> RESP with err = 1, data = 0.
//  - RESP: rsp_valid=1; rsp_data/rsp_err held until rsp_ready; then rsp_valid=0 and IDLE next cycle.
//  - Latency with zero wait states, acceptance edge to rsp_valid:
//    - ADD = 6 + SETTLE_CYC cycles
//    - CLEAR = 4 + SETTLE_CYC cycles
//    - READ = 2 cycles
//  - Results are the slave's value; wrap-around is the slave's modulo-2^DATA_W sum, passed through unchanged.
// CONFIGURATION
//  ACC_SEQ_TIMEOUT_EN defined:
//    - a 5-bit counter counts ACCESS cycles with PREADY=0.
//    - on reaching TIMEOUT: PSEL/PENABLE drop, sequence aborts, RESP with err = 1, data = 0.
//  Not defined: no counter; ACCESS waits for PREADY indefinitely.
// TESTING
//  1. Reset, then READ -> PADDR = 8 read; rsp_data = 0, rsp_err = 0; latency 2 cycles.
//  2. ADD 10, then ADD 5 (PREADY tied 1) -> rsp_data 10 then 15.
//     Each ADD shows 3 APB transfers and 2 PSEL-low cycles before the read.
//  3. ADD 0x7FFFFFFF, then ADD 1, then ADD 0xFFFFFFFF -> 0x7FFFFFFF, 0x80000000, 0x7FFFFFFF.
//     Then CLEAR -> 0.
//  4. PREADY low 3 cycles on every access, ADD 42 -> rsp 42.
//     PADDR/PWDATA stable throughout ACCESS; rsp_ready held low 4 cycles -> rsp held, cmd_ready = 0.
//  5. PSLVERR on the control write -> no result read issued; rsp_err = 1, rsp_data = 0.
//     cmd_op = 3 -> err = 1, no PSEL.
//  6. PRESETn pulsed low during ACCESS of an ADD -> outputs 0 asynchronously; no rsp.
//     Next READ completes normally.
//     With ACC_SEQ_TIMEOUT_EN and PREADY stuck 0 -> err after 16 ACCESS cycles.

Source files
------------

// File: rtl/apb_acc_sequencer.sv
// APB master that runs ADD/CLEAR/READ commands against the accumulator slave and returns the result.
// Optional: define ACC_SEQ_TIMEOUT_EN to abort an ACCESS phase stalled for TIMEOUT cycles.
module apb_acc_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                SETTLE_CYC = 2
`ifdef ACC_SEQ_TIMEOUT_EN
    ,
    parameter int                TIMEOUT    = 16
`endif
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    // Transfer steps; each op starts part-way into this list and runs to the result read.
    localparam logic [1:0] STEP_ADDEND = 2'd0;
    localparam logic [1:0] STEP_CTRL   = 2'd1;
    localparam logic [1:0] STEP_RESULT = 2'd2;

    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_SETTLE, S_RESP} state_t;

    state_t      state_reg;
    logic [1:0]  op_reg;
    logic [1:0]  step_reg;
    logic [3:0]  settle_cnt_reg;
`ifdef ACC_SEQ_TIMEOUT_EN
    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);
    logic [4:0]  wait_cnt_reg;
`endif

    logic [1:0]        ld_op;
    logic [1:0]        ld_step;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_write;
    logic [DATA_W-1:0] ld_wdata;

    // Descriptor of the transfer the next SETUP will present. The addend step is only
    // ever loaded from IDLE, so cmd_data is still the accepted operand there.
    always_comb begin
        ld_op    = (state_reg == S_IDLE) ? cmd_op : op_reg;
        if (state_reg == S_IDLE)
            ld_step = (cmd_op == OP_ADD) ? STEP_ADDEND :
                      (cmd_op == OP_CLEAR) ? STEP_CTRL : STEP_RESULT;
        else if (state_reg == S_ACCESS)
            ld_step = step_reg + 2'd1;
        else
            ld_step = step_reg;
        ld_addr  = BASE_ADDR + ADDR_W'(8);
        ld_write = 1'b0;
        ld_wdata = '0;
        case (ld_step)
            STEP_ADDEND: begin
                ld_addr  = BASE_ADDR;
                ld_write = 1'b1;
                ld_wdata = cmd_data;
            end
            STEP_CTRL: begin
                ld_addr  = BASE_ADDR + ADDR_W'(4);
                ld_write = 1'b1;
                ld_wdata = (ld_op == OP_CLEAR) ? DATA_W'(2) : DATA_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg      <= S_IDLE;
            op_reg         <= OP_ADD;
            step_reg       <= STEP_ADDEND;
            settle_cnt_reg <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            PADDR          <= '0;
            PSEL           <= 1'b0;
            PENABLE        <= 1'b0;
            PWRITE         <= 1'b0;
            PWDATA         <= '0;
`ifdef ACC_SEQ_TIMEOUT_EN
            wait_cnt_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_reg    <= cmd_op;
                        if (cmd_op == OP_RSVD) begin
                            state_reg <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state_reg <= S_SETUP;
                            step_reg  <= ld_step;
                            PSEL      <= 1'b1;
                            PADDR     <= ld_addr;
                            PWRITE    <= ld_write;
                            PWDATA    <= ld_wdata;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    PENABLE   <= 1'b1;
                    state_reg <= S_ACCESS;
`ifdef ACC_SEQ_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        PENABLE <= 1'b0;
                        if (PSLVERR || step_reg == STEP_RESULT) begin
                            PSEL      <= 1'b0;
                            state_reg <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= PSLVERR;
                            rsp_data  <= PSLVERR ? '0 : PRDATA;
                        end else begin
                            step_reg <= ld_step;
                            if (step_reg == STEP_CTRL && SETTLE_CYC != 0) begin
                                PSEL           <= 1'b0;
                                state_reg      <= S_SETTLE;
                                settle_cnt_reg <= SETTLE_LAST;
                            end else begin
                                state_reg <= S_SETUP;
                                PADDR     <= ld_addr;
                                PWRITE    <= ld_write;
                                PWDATA    <= ld_wdata;
                            end
                        end
                    end
`ifdef ACC_SEQ_TIMEOUT_EN
                    else if (wait_cnt_reg == WAIT_LAST) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state_reg <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 5'd1;
                    end
`endif
                end
                S_SETTLE: begin
                    if (settle_cnt_reg == 4'd0) begin
                        state_reg <= S_SETUP;
                        PSEL      <= 1'b1;
                        PADDR     <= ld_addr;
                        PWRITE    <= ld_write;
                        PWDATA    <= ld_wdata;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_acc_sequencer.sv
// Directed bench for apb_acc_sequencer: vector table against an accumulator slave model,
// plus hand-written reset-in-flight and (when ACC_SEQ_TIMEOUT_EN is defined) timeout sequences.
module tb_apb_acc_sequencer;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_acc_sequencer dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Accumulator slave model with programmable wait states and error injection.
    int          ws = 0;
    int          wcnt = 0;
    logic        err_en = 1'b0;
    logic [3:0]  err_nib = 4'h0;
    logic [31:0] acc = '0;
    logic [31:0] addend = '0;

    assign PREADY  = (wcnt >= ws);
    assign PRDATA  = acc;
    assign PSLVERR = err_en && PSEL && PENABLE && PREADY && (PADDR[3:0] == err_nib);

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
            case (PADDR[3:0])
                4'h0: addend <= PWDATA;
                4'h4: begin
                    if (PWDATA == 32'd1) acc <= acc + addend;
                    else if (PWDATA == 32'd2) acc <= '0;
                end
                default: ;
            endcase
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // sig: one nibble per completed transfer = PADDR[3:0] | PWRITE (W0->1, W4->5, R8->8)
    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        int          ws;
        int          err_nib;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_sig;
        int          exp_pl;
    } vec_t;

    vec_t vecs[13];

    task automatic run_vec(input string nm, input vec_t v);
        int k, e, pl, sig, bad;
        logic [31:0] s_addr, s_wd;
        logic s_wr;
        ws      = v.ws;
        err_en  = (v.err_nib >= 0);
        err_nib = 4'(v.err_nib);
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_data  = v.data;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge PCLK);
            k++;
        end
        if (!cmd_ready) begin
            check({nm, " accept"}, 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        e = 0; pl = 0; sig = 0; bad = 0;
        s_addr = '0; s_wd = '0; s_wr = 1'b0;
        forever begin
            @(negedge PCLK);
            if (rsp_valid || e >= 300) break;
            if (!PSEL) pl++;
            if (PSEL && !PENABLE) begin
                s_addr = PADDR; s_wd = PWDATA; s_wr = PWRITE;
            end
            if (PSEL && PENABLE) begin
                if (PADDR != s_addr || PWDATA != s_wd || PWRITE != s_wr) bad++;
                if (PREADY) sig = sig * 16 + int'(PADDR[3:0] | {3'b000, PWRITE});
            end
            @(posedge PCLK);
            e++;
        end
        $display("%s: op=%0d data=%h ws=%0d -> rsp_data=%h rsp_err=%0d lat=%0d xfers=%0h psel_low=%0d",
                 nm, v.op, v.data, v.ws, rsp_data, rsp_err, e, sig, pl);
        check({nm, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({nm, " rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
        check({nm, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
        check({nm, " latency"}, 64'(e), 64'(v.exp_lat));
        check({nm, " apb transfers"}, 64'(sig), 64'(v.exp_sig));
        check({nm, " psel low cycles"}, 64'(pl), 64'(v.exp_pl));
        check({nm, " access stability"}, 64'(bad), 64'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge PCLK);
            check($sformatf("%s hold%0d", nm, h),
                  {30'd0, rsp_valid, cmd_ready, rsp_data},
                  {30'd0, 1'b1, 1'b0, v.exp_data});
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        check({nm, " rsp consumed"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int k, hits;
        vec_t rd;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        //            op     data          ws  err hold exp_data      err  lat sig    pl
        vecs[0]  = '{2'd2, 32'd0,          0, -1, 0, 32'd0,          1'b0, 2,  'h8,   0};
        vecs[1]  = '{2'd0, 32'd10,         0, -1, 0, 32'd10,         1'b0, 8,  'h158, 2};
        vecs[2]  = '{2'd0, 32'd5,          0, -1, 0, 32'd15,         1'b0, 8,  'h158, 2};
        vecs[3]  = '{2'd1, 32'd0,          0, -1, 0, 32'd0,          1'b0, 6,  'h58,  2};
        vecs[4]  = '{2'd0, 32'h7FFFFFFF,   0, -1, 0, 32'h7FFFFFFF,   1'b0, 8,  'h158, 2};
        vecs[5]  = '{2'd0, 32'd1,          0, -1, 0, 32'h80000000,   1'b0, 8,  'h158, 2};
        vecs[6]  = '{2'd0, 32'hFFFFFFFF,   0, -1, 0, 32'h7FFFFFFF,   1'b0, 8,  'h158, 2};
        vecs[7]  = '{2'd1, 32'd0,          0, -1, 0, 32'd0,          1'b0, 6,  'h58,  2};
        vecs[8]  = '{2'd0, 32'd42,         3, -1, 4, 32'd42,         1'b0, 17, 'h158, 2};
        vecs[9]  = '{2'd0, 32'd9,          0,  4, 0, 32'd0,          1'b1, 4,  'h15,  0};
        vecs[10] = '{2'd2, 32'd0,          0, -1, 0, 32'd42,         1'b0, 2,  'h8,   0};
        vecs[11] = '{2'd3, 32'h55,         0, -1, 0, 32'd0,          1'b1, 0,  0,     0};
        vecs[12] = '{2'd2, 32'd0,          2, -1, 0, 32'd42,         1'b0, 4,  'h8,   0};

        #3;
        check("reset cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset psel/penable", {62'd0, PSEL, PENABLE}, 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset paddr", 64'(PADDR), 64'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("cmd_ready after reset", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset pulsed while an ADD sits in ACCESS with wait states: the addend write never completes.
        ws = 5;
        err_en = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_data  = 32'd100;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge PCLK);
            k++;
        end
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        k = 0;
        while (!PENABLE && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        check("mid-reset reached access", 64'(PENABLE), 64'd1);
        #2 PRESETn = 1'b0;
        #1;
        check("mid-reset psel/penable/pwrite", {61'd0, PSEL, PENABLE, PWRITE}, 64'd0);
        check("mid-reset paddr/pwdata", {PADDR, PWDATA}, 64'd0);
        check("mid-reset rsp/cmd_ready", {62'd0, rsp_valid, cmd_ready}, 64'd0);
        $display("reset pulse during ADD access: PSEL=%0d PENABLE=%0d rsp_valid=%0d", PSEL, PENABLE, rsp_valid);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        hits = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) hits++;
        end
        check("no rsp or apb after reset", 64'(hits), 64'd0);

        rd = '{2'd2, 32'd0, 0, -1, 0, 32'd42, 1'b0, 2, 'h8, 0};
        run_vec("read after reset", rd);

`ifdef ACC_SEQ_TIMEOUT_EN
        rd = '{2'd2, 32'd0, 1000, -1, 0, 32'd0, 1'b1, 17, 0, 0};
        run_vec("timeout read", rd);
        ws = 0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
